jt89_noise: RTL and testbench

JT89_NOISE -- requirements
Module: jt89_noise

---
 rtl/jt89_noise.sv | 139 +++++++++++++
 tb/tb_jt89_noise.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/jt89_noise.sv
// rtl/jt89_noise.sv - SN76489/SMS noise channel: rate counter, LFSR and volume mapping
//
// Optional feature: define JT89_LFSR16_EN for the 16-bit SMS LFSR
// (seed 0x8000, taps 0/3). Default is the 15-bit SN76489 LFSR
// (seed 0x4000, taps 0/1). Bit 0 is the output in both builds.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   clk_en     tone-rate enable, gates all counting
//   din[2:0]   noise control: [2] 1=white 0=periodic, [1:0] shift rate
//   ctrl_we    one-cycle write strobe for din (not gated by clk_en)
//   vol[3:0]   attenuation, 0 loudest, 15 silent
//   ch2_toggle one-cycle pulse per tone-channel-2 output flip
//   noise[8:0] registered unsigned amplitude to the mixer

module jt89_noise (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [2:0] din,
    input  logic       ctrl_we,
    input  logic [3:0] vol,
    input  logic       ch2_toggle,
    output logic [8:0] noise
);

`ifdef JT89_LFSR16_EN
    localparam int W   = 16;
    localparam int TAP = 3;
`else
    localparam int W   = 15;
    localparam int TAP = 1;
`endif
    localparam logic [W-1:0] SEED = {1'b1, {(W-1){1'b0}}};

    logic [2:0]   ctrl_q, ctrl_d;
    logic [6:0]   cnt_q, cnt_d;
    logic         ff_q, ff_d;
    logic [W-1:0] lfsr_q, lfsr_d;
    logic [8:0]   noise_q, noise_d;
    logic         expire;
    logic         shift;
    logic         fb;

    // Counter reload for each rate; rate 11 does not use the counter.
    function automatic logic [6:0] reload_val(input logic [1:0] rate);
        case (rate)
            2'b01:   reload_val = 7'd32;
            2'b10:   reload_val = 7'd64;
            default: reload_val = 7'd16;
        endcase
    endfunction

    function automatic logic [8:0] amp(input logic [3:0] v);
        case (v)
            4'd0:    amp = 9'd511;
            4'd1:    amp = 9'd406;
            4'd2:    amp = 9'd322;
            4'd3:    amp = 9'd256;
            4'd4:    amp = 9'd203;
            4'd5:    amp = 9'd162;
            4'd6:    amp = 9'd128;
            4'd7:    amp = 9'd102;
            4'd8:    amp = 9'd81;
            4'd9:    amp = 9'd64;
            4'd10:   amp = 9'd51;
            4'd11:   amp = 9'd41;
            4'd12:   amp = 9'd32;
            4'd13:   amp = 9'd26;
            4'd14:   amp = 9'd20;
            default: amp = 9'd0;
        endcase
    endfunction

    always_comb begin
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;
        ff_d   = ff_q;
        lfsr_d = lfsr_q;
        expire = 1'b0;
        shift  = 1'b0;

        if (ctrl_q[1:0] == 2'b11) begin
            expire = ch2_toggle;
        end else if (clk_en) begin
            if (cnt_q == 7'd1) begin
                cnt_d  = reload_val(ctrl_q[1:0]);
                expire = 1'b1;
            end else begin
                cnt_d = cnt_q - 7'd1;
            end
        end

        // ff halves the expire rate; the LFSR advances on its rising edge.
        if (expire) begin
            ff_d  = ~ff_q;
            shift = ~ff_q;
        end

        fb = ctrl_q[2] ? (lfsr_q[0] ^ lfsr_q[TAP]) : lfsr_q[0];

        // A stuck all-zero register would silence the channel forever.
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end else if (shift) begin
            lfsr_d = {fb, lfsr_q[W-1:1]};
        end

        // A control write restarts the channel and overrides any shift.
        if (ctrl_we) begin
            ctrl_d = din;
            cnt_d  = reload_val(din[1:0]);
            ff_d   = 1'b0;
            lfsr_d = SEED;
        end

        noise_d = lfsr_q[0] ? amp(vol) : 9'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= 3'b000;
            cnt_q   <= 7'd16;
            ff_q    <= 1'b0;
            lfsr_q  <= SEED;
            noise_q <= 9'd0;
        end else begin
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            ff_q    <= ff_d;
            lfsr_q  <= lfsr_d;
            noise_q <= noise_d;
        end
    end

    assign noise = noise_q;

endmodule

// File: tb/tb_jt89_noise.sv
// tb/tb_jt89_noise.sv - self-checking bench for jt89_noise against a behavioural model
module tb_jt89_noise;

`ifdef JT89_LFSR16_EN
    localparam int W   = 16;
    localparam int TAP = 3;
`else
    localparam int W   = 15;
    localparam int TAP = 1;
`endif
    localparam int SEED = 1 << (W - 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic [2:0] din = 3'b000;
    logic       ctrl_we = 1'b0;
    logic [3:0] vol = 4'd0;
    logic       ch2_toggle = 1'b0;
    logic [8:0] noise;

    jt89_noise dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .din        (din),
        .ctrl_we    (ctrl_we),
        .vol        (vol),
        .ch2_toggle (ch2_toggle),
        .noise      (noise)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int amp_tab [16] = '{511, 406, 322, 256, 203, 162, 128, 102,
                         81, 64, 51, 41, 32, 26, 20, 0};

    // Model state: LFSR value, control, clk_en pulses and expire events since restart.
    int       m_lfsr;
    logic [2:0] m_ctrl;
    int       m_k;
    int       m_exp;
    int       m_shifts = 0;
    int       m_noise = 0;

    function automatic int golden_shift(input int s, input bit white);
        int fb;
        fb = white ? ((s ^ (s >> TAP)) & 1) : (s & 1);
        return (s >> 1) | (fb << (W - 1));
    endfunction

    function automatic int period(input logic [1:0] r);
        return 16 << r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl  = 3'b000;
        m_lfsr  = SEED;
        m_k     = 0;
        m_exp   = 0;
        m_noise = 0;
    endtask

    // One clock: check the previous edge's result, drive inputs, advance the model.
    task automatic step(input bit ce, input bit we, input logic [2:0] d,
                        input logic [3:0] v, input bit t2);
        bit expire;
        @(negedge clk);
        check("noise", {23'd0, noise}, m_noise);
        clk_en = ce; ctrl_we = we; din = d; vol = v; ch2_toggle = t2;
        if (rst) begin
            m_noise = 0;
        end else begin
            m_noise = (m_lfsr & 1) ? amp_tab[v] : 0;
            if (we) begin
                m_ctrl = d; m_lfsr = SEED; m_k = 0; m_exp = 0;
            end else begin
                expire = 1'b0;
                if (m_ctrl[1:0] == 2'b11) begin
                    expire = t2;
                end else if (ce) begin
                    m_k++;
                    expire = (m_k % period(m_ctrl[1:0])) == 0;
                end
                if (expire) begin
                    m_exp++;
                    if (m_exp % 2 == 1) begin
                        m_lfsr = golden_shift(m_lfsr, m_ctrl[2]);
                        m_shifts++;
                    end
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        check("noise", {23'd0, noise}, m_noise);
        #2 rst = 1'b1;
        #1 check("async_rst", {23'd0, noise}, 0);
        model_reset();
        repeat (n) step(1'($urandom), 1'b0, 3'($urandom), 4'($urandom), 1'($urandom));
        @(negedge clk);
        check("rst_hold", {23'd0, noise}, 0);
        check("rst_lfsr", {{(32-W){1'b0}}, dut.lfsr_q}, SEED);
        rst = 1'b0;
        clk_en = 1'b0; ctrl_we = 1'b0; ch2_toggle = 1'b0; vol = 4'd0;
        m_noise = 0;
    endtask

    task automatic lfsr_after_edge(input string tag, input int exp);
        @(posedge clk);
        #1 check(tag, {{(32-W){1'b0}}, dut.lfsr_q}, exp);
    endtask

    initial begin
        int s0;
        int g;
        model_reset();

        // Reset with clk_en free-running, then release at full volume.
        do_reset(20);
        repeat (700) step(1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
        lfsr_after_edge("lfsr_after_reset_run", m_lfsr);

        // Periodic, rate 00.
        step(1'b0, 1'b1, 3'b000, 4'd0, 1'b0);
        repeat (1100) step(1'b1, 1'b0, 3'b000, 4'd0, 1'b0);

        // White noise for 1000 shifts.
        step(1'b0, 1'b1, 3'b100, 4'd0, 1'b0);
        s0 = m_shifts;
        g = 0;
        while (m_shifts - s0 < 1000 && g < 40000) begin
            step(1'b1, 1'b0, 3'b100, 4'd0, 1'b0);
            g++;
            if (g % 997 == 0) check("lfsr_nonzero", {31'd0, dut.lfsr_q != '0}, 1);
        end
        if (m_shifts - s0 < 1000) check("white_timeout", 0, 1);
        lfsr_after_edge("lfsr_white", m_lfsr);

        // Rates 01 and 10, white and periodic, sparse clk_en, random volume.
        step(1'b0, 1'b1, 3'b101, 4'd0, 1'b0);
        repeat (3000) step(1'($urandom), 1'b0, 3'b101, 4'($urandom), 1'b0);
        step(1'b0, 1'b1, 3'b010, 4'd0, 1'b0);
        repeat (3000) step(1'($urandom), 1'b0, 3'b010, 4'($urandom), 1'b0);

        // Reset mid-period, then resume from the reset state.
        do_reset(5);
        repeat (600) step(1'b1, 1'b0, 3'b000, 4'($urandom), 1'b0);

        // Tone-2 rate: toggles every 10 clk, clk_en random and ignored.
        step(1'b0, 1'b1, 3'b111, 4'd0, 1'b0);
        for (int i = 0; i < 600; i++)
            step(1'($urandom), 1'b0, 3'b111, 4'd0, (i % 10) == 9);
        lfsr_after_edge("lfsr_tone2", m_lfsr);

        // Write coinciding with a shift: seed next cycle, new rate 64 applies.
        step(1'b0, 1'b1, 3'b000, 4'd0, 1'b0);
        repeat (15) step(1'b1, 1'b0, 3'b000, 4'd0, 1'b0);
        step(1'b1, 1'b1, 3'b010, 4'd0, 1'b0);
        lfsr_after_edge("wr_shift_seed", SEED);
        repeat (63) step(1'b1, 1'b0, 3'b010, 4'd0, 1'b0);
        lfsr_after_edge("new_rate_no_shift", SEED);
        step(1'b1, 1'b0, 3'b010, 4'd0, 1'b0);
        lfsr_after_edge("new_rate_first_shift", golden_shift(SEED, 1'b0));

        // Volume sweep with LFSR bit 0 held at 1 (tone-2 rate, toggles stopped).
        step(1'b0, 1'b1, 3'b011, 4'd0, 1'b0);
        g = 0;
        while (!(m_lfsr & 1) && g < 100) begin
            step(1'b1, 1'b0, 3'b011, 4'd0, g[0]);
            g++;
        end
        if (!(m_lfsr & 1)) check("vol_setup_timeout", 0, 1);
        for (int v = 0; v < 16; v++) begin
            step(1'($urandom), 1'b0, 3'b011, 4'(v), 1'b0);
            @(posedge clk);
            #1 check("vol_tab", {23'd0, noise}, amp_tab[v]);
        end
        step(1'b0, 1'b0, 3'b011, 4'd15, 1'b0);
        step(1'b0, 1'b0, 3'b011, 4'd0, 1'b0);
        step(1'b0, 1'b0, 3'b011, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
